imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
Shares the single memory port between the instruction-cache refill path and the data-cache refill/writeback path. Each cache raises one line-sized transaction. The arbiter picks a winner round-robin, locks the port for the whole burst, and issues BEATS word requests on the memory handshake. Read data is forwarded per beat to the winner. Sits between both cache controllers and the memory model.

Parameters:
BEATS, 4, words per line transaction (power of 2, ≥2)
ADDR_W, 32, address width
DATA_W, 32, data word width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-low reset
ic_req_valid  in  1  I-cache line read request; held until ic_done
ic_req_addr  in  ADDR_W  any byte address within the line
ic_beat_valid  out  1  ic_rdata holds a valid beat this cycle
ic_rdata  out  DATA_W  refill word
ic_done  out  1  one-cycle pulse: transaction complete
dc_req_valid  in  1  D-cache line request; held until dc_done
dc_req_wr  in  1  1 = line write, 0 = line read; stable while valid
dc_req_addr  in  ADDR_W  any byte address within the line
dc_wdata  in  DATA_W  write word for the current beat
dc_beat_valid  out  1  beat accepted by memory (read: dc_rdata valid; write: advance dc_wdata)
dc_rdata  out  DATA_W  refill word
dc_done  out  1  one-cycle pulse: transaction complete
mem_req_valid  out  1  memory request
mem_req_wr  out  1  write enable
mem_req_addr  out  ADDR_W  word address (byte-addressed, 4-aligned)
mem_wr_data  out  DATA_W  write data
mem_req_ready  in  1  memory accepts the beat; read data valid the same cycle
mem_req_data  in  DATA_W  read data

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, beat=0, last_grant=DC, so IC wins the first tie.
  - All outputs 0, including registered data outputs.
  - Reset mid-burst abandons the transaction. mem_req_valid is 0 from the next cycle. No done pulse is issued.
- FSM IDLE:
  - Sample requests and choose a winner. A single requester wins.
  - When both request, the winner is the one not equal to last_grant.
  - Latch owner, wr (IC is always read), and base = addr with the low log2(BEATS*4) bits cleared.
  - Go to BUSY. No output changes this cycle.
- FSM BUSY:
  - Drive mem_req_valid=1, mem_req_addr = base + beat*4, mem_req_wr = latched wr.
  - mem_wr_data = dc_wdata, combinational pass-through, valid only when the owner is DC and wr=1.
  - Hold the request while mem_req_ready=0. Any number of wait cycles is legal.
  - A beat completes on the cycle where mem_req_valid && mem_req_ready:
    - Owner's beat_valid=1 that cycle (combinational).
    - Owner's rdata = mem_req_data (pass-through).
    - beat increments.
  - Address arithmetic is modulo 2^ADDR_W. Base is line-aligned, so bursts never cross a line boundary.
  - On the completed beat with beat==BEATS-1: beat←0, last_grant←owner, go to DONE.
- FSM DONE:
  - mem_req_valid=0. Owner's done=1 for exactly one cycle. Go to IDLE.
  - Minimum turnaround: 1 idle cycle before the next grant.
  - Back-to-back transactions are therefore BEATS + 2 cycles apart with zero memory wait states.
- Requester drops valid mid-burst: ignored, the burst completes. The done pulse is still issued and the requester must tolerate it.
- The non-owner's beat_valid, rdata and done stay 0 throughout.
- A request arriving while BUSY/DONE waits. It is never lost as long as valid is held.
- Fairness: with both requesting continuously, grants strictly alternate IC, DC, IC, …
- A requester must deassert valid in the cycle after its done pulse, or it is treated as a new request.

Decomposition:
- Shared header mem_arb.vh holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2
  - owner IDs OWN_IC=1'b0, OWN_DC=1'b1
  - BYTES_PER_BEAT=4
- Sub-module rr_arb2: combinational 2-way round-robin pick from {req_ic, req_dc, last_grant}, returning a grant ID and a grant-valid bit. It is reused later for a write-buffer port.

Test Plan:
- Reset, then ic_req_valid=1, addr=0x0000_1234, mem_req_ready=1 → mem addrs 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles; 4 ic_beat_valid pulses carrying the memory data; ic_done one cycle later; all dc_* outputs stay 0.
- Both request at the same cycle after reset → IC granted first, then DC. With both held continuously, grants alternate IC, DC, IC over 3 transactions, each BEATS + 2 cycles apart.
- DC write, addr=0x8000_0010, mem_req_ready toggling 0/1 → each beat held stable with mem_req_wr=1 until ready. mem_wr_data matches dc_wdata. dc_beat_valid fires only on ready cycles, 4 total.
- Wrap: dc read addr=0xFFFF_FFF8 → addrs 0xFFFF_FFF0..0xFFFF_FFFC. No overflow past the line; beat counter returns to 0.
- Reset asserted during beat 2 of an IC burst → mem_req_valid=0 next cycle, no ic_done. After reset release, a fresh IC request restarts at beat 0.
- ic_req_valid dropped after beat 1 → burst still completes 4 beats and ic_done pulses. A DC request pending meanwhile is granted after DONE.

Source files
------------

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared encodings for the I-cache / D-cache memory port arbiter.
// The state, owner and beat-size definitions live here so the arbiter and its sub-module agree on them.
package imem_dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  localparam int BYTES_PER_BEAT = 4;

endpackage

// File: rtl/imem_dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on a tie the side not granted last wins.
// Purely combinational so it can be reused for other two-port shares.
module rr_arb2
  import imem_dmem_arbiter_pkg::*;
(
  input  logic req_ic,
  input  logic req_dc,
  input  logic last_grant,
  output logic gnt_id,
  output logic gnt_valid
);

  assign gnt_valid = req_ic | req_dc;
  assign gnt_id    = (req_ic && req_dc) ? ~last_grant : (req_dc ? OWN_DC : OWN_IC);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between I-cache refills and D-cache refills/writebacks,
// locking the port for a full BEATS-word line burst per grant.
//
// state | meaning
// IDLE  | pick a winner, latch owner / direction / line base
// BUSY  | issue beats to memory, forward each accepted beat to the owner
// DONE  | one-cycle done pulse to the owner, port released
module imem_dmem_arbiter
  import imem_dmem_arbiter_pkg::*;
#(
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_beat_valid,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_req_valid,
  input  logic              dc_req_wr,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_beat_valid,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  output logic              mem_req_valid,
  output logic              mem_req_wr,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_req_ready,
  input  logic [DATA_W-1:0] mem_req_data
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFS_W  = $clog2(BEATS * BYTES_PER_BEAT);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFS_W){1'b1}}, {OFS_W{1'b0}}};
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                gnt_id, gnt_valid;

  rr_arb2 u_rr_arb2 (
    .req_ic     (ic_req_valid),
    .req_dc     (dc_req_valid),
    .last_grant (last_grant_q),
    .gnt_id     (gnt_id),
    .gnt_valid  (gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      last_grant_q <= OWN_DC;
      owner_q      <= OWN_IC;
      wr_q         <= 1'b0;
      base_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      base_q       <= base_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    wr_d          = wr_q;
    base_d        = base_q;
    ic_beat_valid = 1'b0;
    ic_rdata      = '0;
    ic_done       = 1'b0;
    dc_beat_valid = 1'b0;
    dc_rdata      = '0;
    dc_done       = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_wr    = 1'b0;
    mem_req_addr  = '0;
    mem_wr_data   = '0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d = gnt_id;
          wr_d    = (gnt_id == OWN_DC) ? dc_req_wr : 1'b0;
          base_d  = ((gnt_id == OWN_DC) ? dc_req_addr : ic_req_addr) & LINE_MASK;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mem_req_valid = 1'b1;
        mem_req_wr    = wr_q;
        // base is line-aligned, so the beat offset never carries out of the line
        mem_req_addr  = base_q + ADDR_W'({beat_q, 2'b00});
        mem_wr_data   = (owner_q == OWN_DC && wr_q) ? dc_wdata : '0;
        if (mem_req_ready) begin
          if (owner_q == OWN_DC) begin
            dc_beat_valid = 1'b1;
            dc_rdata      = mem_req_data;
          end else begin
            ic_beat_valid = 1'b1;
            ic_rdata      = mem_req_data;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d       = '0;
            last_grant_d = owner_q;
            state_d      = DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DONE: begin
        ic_done = (owner_q == OWN_IC);
        dc_done = (owner_q == OWN_DC);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: single IC refill, tie alternation, stalled DC write,
// address wrap at the top of memory, reset mid-burst and a requester dropping valid mid-burst.
module tb_imem_dmem_arbiter;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_beat_valid;
  logic [31:0] ic_rdata;
  logic        ic_done;
  logic        dc_req_valid;
  logic        dc_req_wr;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_wdata;
  logic        dc_beat_valid;
  logic [31:0] dc_rdata;
  logic        dc_done;
  logic        mem_req_valid;
  logic        mem_req_wr;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_wr_data;
  logic        mem_req_ready;
  logic [31:0] mem_req_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dc_beats = 0;
  int start_prev;

  always #5 clk = ~clk;

  // memory model: each word reads back as its address scrambled with KEY
  assign mem_req_data = mem_req_addr ^ KEY;

  always @(negedge clk) if (dc_beat_valid) dc_beats++;

  imem_dmem_arbiter #(.BEATS(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ic_req_valid  (ic_req_valid),
    .ic_req_addr   (ic_req_addr),
    .ic_beat_valid (ic_beat_valid),
    .ic_rdata      (ic_rdata),
    .ic_done       (ic_done),
    .dc_req_valid  (dc_req_valid),
    .dc_req_wr     (dc_req_wr),
    .dc_req_addr   (dc_req_addr),
    .dc_wdata      (dc_wdata),
    .dc_beat_valid (dc_beat_valid),
    .dc_rdata      (dc_rdata),
    .dc_done       (dc_done),
    .mem_req_valid (mem_req_valid),
    .mem_req_wr    (mem_req_wr),
    .mem_req_addr  (mem_req_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_req_ready (mem_req_ready),
    .mem_req_data  (mem_req_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #2;
  endtask

  // completed read/write beat owned by own_dc, at the given address
  task automatic chk_beat(input string tag, input logic own_dc, input logic [31:0] addr,
                          input logic wr);
    chk({tag, "_valid"}, {31'd0, mem_req_valid}, 32'd1);
    chk({tag, "_addr"}, mem_req_addr, addr);
    chk({tag, "_wr"}, {31'd0, mem_req_wr}, {31'd0, wr});
    chk({tag, "_ic_bv"}, {31'd0, ic_beat_valid}, {31'd0, ~own_dc});
    chk({tag, "_dc_bv"}, {31'd0, dc_beat_valid}, {31'd0, own_dc});
    chk({tag, "_ic_rd"}, ic_rdata, own_dc ? 32'd0 : (addr ^ KEY));
    chk({tag, "_dc_rd"}, dc_rdata, own_dc ? (addr ^ KEY) : 32'd0);
  endtask

  task automatic chk_done(input string tag, input logic own_dc);
    chk({tag, "_mv"}, {31'd0, mem_req_valid}, 32'd0);
    chk({tag, "_icd"}, {31'd0, ic_done}, {31'd0, ~own_dc});
    chk({tag, "_dcd"}, {31'd0, dc_done}, {31'd0, own_dc});
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_wr = 1'b0; dc_req_addr = '0; dc_wdata = '0;
    mem_req_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_mv", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_addr", mem_req_addr, 32'd0);
    chk("rst_icbv", {31'd0, ic_beat_valid}, 32'd0);
    chk("rst_dcbv", {31'd0, dc_beat_valid}, 32'd0);
    chk("rst_icrd", ic_rdata, 32'd0);
    chk("rst_dcrd", dc_rdata, 32'd0);
    chk("rst_done", {30'd0, ic_done, dc_done}, 32'd0);

    // single IC refill, zero wait states
    rst = 1'b1; ic_req_valid = 1'b1; ic_req_addr = 32'h0000_1234; mem_req_ready = 1'b1;
    #1;
    chk("t1_idle_mv", {31'd0, mem_req_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk_beat("t1_beat", 1'b0, 32'h0000_1230 + 32'(k) * 4, 1'b0);
    end
    tick(); #1;
    chk_done("t1_done", 1'b0);
    ic_req_valid = 1'b0;
    tick(); #1;
    chk("t1_after_icd", {31'd0, ic_done}, 32'd0);
    chk("t1_after_mv", {31'd0, mem_req_valid}, 32'd0);

    // tie after reset: IC first, then strict alternation, BEATS+2 cycles apart
    do_reset();
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_0100;
    dc_req_valid = 1'b1; dc_req_wr = 1'b0; dc_req_addr = 32'h0000_0204;
    start_prev = 0;
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 4; k++) begin
        tick(); #1;
        if (k == 0) begin
          if (t > 0) chk("t2_period", 32'(cyc - start_prev), 32'd6);
          start_prev = cyc;
        end
        chk_beat("t2_beat", t[0], (t[0] ? 32'h0000_0200 : 32'h0000_0100) + 32'(k) * 4, 1'b0);
      end
      tick(); #1;
      chk_done("t2_done", t[0]);
      if (t == 2) begin
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
      end
      tick(); #1;
      chk("t2_idle_mv", {31'd0, mem_req_valid}, 32'd0);
    end

    // DC write with memory stalling every other cycle
    dc_beats = 0;
    dc_req_valid = 1'b1; dc_req_wr = 1'b1; dc_req_addr = 32'h8000_0010; mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      dc_wdata = 32'hD000_0000 + 32'(k); mem_req_ready = 1'b0;
      #1;
      chk("t3_stall_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("t3_stall_addr", mem_req_addr, 32'h8000_0010 + 32'(k) * 4);
      chk("t3_stall_wr", {31'd0, mem_req_wr}, 32'd1);
      chk("t3_stall_wdata", mem_wr_data, 32'hD000_0000 + 32'(k));
      chk("t3_stall_bv", {30'd0, ic_beat_valid, dc_beat_valid}, 32'd0);
      mem_req_ready = 1'b1;
      #1;
      chk("t3_rdy_addr", mem_req_addr, 32'h8000_0010 + 32'(k) * 4);
      chk("t3_rdy_wdata", mem_wr_data, 32'hD000_0000 + 32'(k));
      chk("t3_rdy_bv", {30'd0, ic_beat_valid, dc_beat_valid}, 32'd1);
    end
    tick(); #1;
    chk_done("t3_done", 1'b1);
    chk("t3_beats", 32'(dc_beats), 32'd4);
    dc_req_valid = 1'b0; dc_req_wr = 1'b0; dc_wdata = '0;
    tick();

    // DC read of the top line of the address space
    dc_req_valid = 1'b1; dc_req_addr = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk_beat("t4_beat", 1'b1, 32'hFFFF_FFF0 + 32'(k) * 4, 1'b0);
    end
    tick(); #1;
    chk_done("t4_done", 1'b1);
    dc_req_valid = 1'b0;
    tick(); #1;
    chk("t4_idle_addr", mem_req_addr, 32'd0);

    // reset during beat 2 of an IC burst, then a fresh burst restarts at beat 0
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_0040;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("t5_pre_addr", mem_req_addr, 32'h0000_0040 + 32'(k) * 4);
    end
    rst = 1'b0;
    tick(); #1;
    chk("t5_rst_mv", {31'd0, mem_req_valid}, 32'd0);
    chk("t5_rst_icd", {31'd0, ic_done}, 32'd0);
    tick(); #1;
    chk("t5_rst2_icd", {31'd0, ic_done}, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk_beat("t5_beat", 1'b0, 32'h0000_0040 + 32'(k) * 4, 1'b0);
    end
    tick(); #1;
    chk_done("t5_done", 1'b0);
    ic_req_valid = 1'b0;
    tick();

    // IC drops valid after beat 1, DC waits and is granted after DONE
    ic_req_valid = 1'b1; ic_req_addr = 32'h0000_0300;
    tick(); #1;
    chk_beat("t6_ic", 1'b0, 32'h0000_0300, 1'b0);
    dc_req_valid = 1'b1; dc_req_wr = 1'b0; dc_req_addr = 32'h0000_0500;
    tick(); #1;
    chk_beat("t6_ic", 1'b0, 32'h0000_0304, 1'b0);
    ic_req_valid = 1'b0;
    for (int k = 2; k < 4; k++) begin
      tick(); #1;
      chk_beat("t6_ic", 1'b0, 32'h0000_0300 + 32'(k) * 4, 1'b0);
    end
    tick(); #1;
    chk_done("t6_icdone", 1'b0);
    tick(); #1;
    chk("t6_idle_mv", {31'd0, mem_req_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      chk_beat("t6_dc", 1'b1, 32'h0000_0500 + 32'(k) * 4, 1'b0);
    end
    tick(); #1;
    chk_done("t6_dcdone", 1'b1);
    dc_req_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
